tank_motion: RTL and testbench
==============================

TANK_MOTION -- requirements
Module: tank_motion

Interface
REQ-001 SHALL have parameter Width, default 10'd50, meaning tank sprite width in pixels.
REQ-002 SHALL have parameter Height, default 10'd50, meaning tank sprite height in pixels.
REQ-003 SHALL have parameter Step, default 10'd2, meaning pixels moved per accepted frame.
REQ-004 SHALL have parameter X_Max, default 10'd639, meaning rightmost visible column.
REQ-005 SHALL have parameter Y_Max, default 10'd479, meaning bottom visible row.
REQ-006 SHALL have parameter X_Start, default 10'd295, meaning tankX after reset.
REQ-007 SHALL have parameter Y_Start, default 10'd215, meaning tankY after reset.
REQ-008 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 SHALL have port Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-010 SHALL have port frame_clk, input, 1 bit: vertical-sync-rate strobe, asynchronous to motion timing and sampled on Clk.
REQ-011 SHALL have port keycode, input, 8 bits: current USB HID keycode, where 0x00 means no key.
REQ-012 SHALL have ports DrawX and DrawY, input, 10 bits each: current pixel coordinates.
REQ-013 SHALL have ports tankX and tankY, output, 10 bits each: top-left corner of the tank sprite.
REQ-014 SHALL have port tank_dir, output, 3 bits: facing direction (001 up, 010 right, 011 left, 100 down).
REQ-015 SHALL have port is_tank, output, 1 bit: current pixel lies inside the tank sprite.
REQ-016 SHALL have port moving, output, 1 bit: high while the state machine is in MOVE.

Function
REQ-017 SHALL register frame_clk once per Clk and generate frame_tick, a single-cycle pulse on a 0->1 transition of the registered value.
REQ-018 SHALL map keycodes to directions: 0x1A (W) -> 001, 0x07 (D) -> 010, 0x04 (A) -> 011, 0x16 (S) -> 100; any other code, including 0x00, is "no direction".
REQ-019 SHALL implement an FSM with states IDLE, TURN and MOVE, evaluated only in cycles where frame_tick=1; all outputs hold in every other cycle.
REQ-020 SHALL, on frame_tick with no direction: go to IDLE, leave tankX/tankY unchanged, and hold tank_dir.
REQ-021 SHALL, on frame_tick with direction d != tank_dir: load d into tank_dir, go to TURN, and leave position unchanged (rotation only, no translation that frame).
REQ-022 SHALL, on frame_tick with direction d == tank_dir: go to MOVE and step the position by Step in direction d.
REQ-023 SHALL use 11-bit signed intermediates for the step and clamp the result to 0 <= tankX <= X_Max-Width+1 (590) and 0 <= tankY <= Y_Max-Height+1 (430); no wrap-around.
REQ-024 SHALL remain in MOVE while clamped at an edge, with position held at the limit.
REQ-025 SHALL sample keycode only in the frame_tick cycle; keycode changes between ticks have no effect.
REQ-026 SHALL drive is_tank combinationally: 1 iff tankX <= DrawX <= tankX+Width-1 and tankY <= DrawY <= tankY+Height-1, computed at 11-bit width to avoid overflow.
REQ-027 SHALL drive moving as 1 iff the state is MOVE, registered.
REQ-028 SHALL update tankX, tankY, tank_dir and the state on the Clk edge that follows the frame_tick cycle (latency 1 Clk).

Reset
REQ-029 SHALL, while Reset=1, immediately force: tankX=X_Start, tankY=Y_Start, tank_dir=001, state IDLE, moving=0, registered frame_clk=0, and no frame_tick.
REQ-030 SHALL abandon any in-progress turn or move when Reset is asserted mid-operation; the first frame_tick after release is treated as a fresh evaluation from IDLE.

Verification
REQ-031 SHALL be verified by: Reset pulse -> tankX=295, tankY=215, tank_dir=001, moving=0, is_tank=1 at DrawX=295, DrawY=215 and is_tank=0 at DrawX=345.
REQ-032 SHALL be verified by: keycode=0x07 for 3 frame ticks from reset -> tick1: tank_dir=010, position unchanged; tick2: tankX=297; tick3: tankX=299, moving=1.
REQ-033 SHALL be verified by: tankX=589, dir=010, keycode=0x07, one tick -> tankX=590; further ticks -> tankX stays 590, moving=1.
REQ-034 SHALL be verified by: tankY=1, dir=001, keycode=0x1A, one tick -> tankY=0 with no wrap to 1023.
REQ-035 SHALL be verified by: keycode toggled 0x04 -> 0x00 between ticks with 0x00 at the tick -> state IDLE, tank_dir and position unchanged.
REQ-036 SHALL be verified by: Reset asserted asynchronously mid-frame while MOVE and moving=1 -> outputs return to reset values without waiting for a Clk edge.

Source files
------------

// File: rtl/tank_motion.sv
`default_nettype none
// ============================================================================
// Module   : tank_motion
// Purpose  : Keyboard-driven tank sprite position/orientation controller.
//            A frame-rate strobe (frame_clk) is edge-detected in the Clk
//            domain; on each detected frame the current keycode selects a
//            direction. A new direction only rotates the tank (TURN); the
//            same direction as the current facing translates it by Step
//            pixels (MOVE), clamped to the visible area. No key -> IDLE.
// Ports    : Clk       - system clock, rising edge
//            Reset     - asynchronous active-high reset
//            frame_clk - vsync-rate strobe, sampled on Clk
//            keycode   - USB HID keycode (0x00 = no key)
//            DrawX/Y   - current pixel coordinate being drawn
//            tankX/Y   - sprite top-left corner
//            tank_dir  - facing: 001 up, 010 right, 011 left, 100 down
//            is_tank   - current pixel lies inside the sprite
//            moving    - high while in the MOVE state
// Revision : 1.0 - initial release
// ============================================================================
module tank_motion #(
    parameter logic [9:0] Width   = 10'd50,
    parameter logic [9:0] Height  = 10'd50,
    parameter logic [9:0] Step    = 10'd2,
    parameter logic [9:0] X_Max   = 10'd639,
    parameter logic [9:0] Y_Max   = 10'd479,
    parameter logic [9:0] X_Start = 10'd295,
    parameter logic [9:0] Y_Start = 10'd215
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] tankX,
    output logic [9:0] tankY,
    output logic [2:0] tank_dir,
    output logic       is_tank,
    output logic       moving
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_TURN = 2'd1;
    localparam logic [1:0] c_S_MOVE = 2'd2;

    localparam logic [2:0] c_DIR_NONE  = 3'b000;
    localparam logic [2:0] c_DIR_UP    = 3'b001;
    localparam logic [2:0] c_DIR_RIGHT = 3'b010;
    localparam logic [2:0] c_DIR_LEFT  = 3'b011;
    localparam logic [2:0] c_DIR_DOWN  = 3'b100;

    // Largest legal top-left coordinates so the whole sprite stays visible.
    localparam logic signed [10:0] c_X_LIM = $signed({1'b0, X_Max - Width + 10'd1});
    localparam logic signed [10:0] c_Y_LIM = $signed({1'b0, Y_Max - Height + 10'd1});
    localparam logic signed [10:0] c_STEP  = $signed({1'b0, Step});

    logic             r_frame_q;
    logic             r_frame_q_d;
    logic             w_frame_tick;
    logic [1:0]       r_state;
    logic [2:0]       w_key_dir;
    logic signed [10:0] w_x_sum;
    logic signed [10:0] w_y_sum;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;

    // frame_clk is first captured, then compared with its delayed copy so
    // only a clean rising transition produces a one-cycle tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frame_q   <= 1'b0;
            r_frame_q_d <= 1'b0;
        end else begin
            r_frame_q   <= frame_clk;
            r_frame_q_d <= r_frame_q;
        end
    end

    assign w_frame_tick = r_frame_q & ~r_frame_q_d;

    always_comb begin
        w_key_dir = c_DIR_NONE;
        case (keycode)
            8'h1A:   w_key_dir = c_DIR_UP;
            8'h07:   w_key_dir = c_DIR_RIGHT;
            8'h04:   w_key_dir = c_DIR_LEFT;
            8'h16:   w_key_dir = c_DIR_DOWN;
            default: w_key_dir = c_DIR_NONE;
        endcase
    end

    // Signed 11-bit step so an underflow shows as negative instead of
    // wrapping to a large unsigned value; the result is then clamped.
    always_comb begin
        w_x_sum = $signed({1'b0, tankX});
        w_y_sum = $signed({1'b0, tankY});
        case (w_key_dir)
            c_DIR_UP:    w_y_sum = $signed({1'b0, tankY}) - c_STEP;
            c_DIR_DOWN:  w_y_sum = $signed({1'b0, tankY}) + c_STEP;
            c_DIR_LEFT:  w_x_sum = $signed({1'b0, tankX}) - c_STEP;
            c_DIR_RIGHT: w_x_sum = $signed({1'b0, tankX}) + c_STEP;
            default: ;
        endcase

        if (w_x_sum < 11'sd0)
            w_x_next = 10'd0;
        else if (w_x_sum > c_X_LIM)
            w_x_next = c_X_LIM[9:0];
        else
            w_x_next = w_x_sum[9:0];

        if (w_y_sum < 11'sd0)
            w_y_next = 10'd0;
        else if (w_y_sum > c_Y_LIM)
            w_y_next = c_Y_LIM[9:0];
        else
            w_y_next = w_y_sum[9:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= c_S_IDLE;
            tankX    <= X_Start;
            tankY    <= Y_Start;
            tank_dir <= c_DIR_UP;
        end else if (w_frame_tick) begin
            if (w_key_dir == c_DIR_NONE) begin
                r_state <= c_S_IDLE;
            end else if (w_key_dir != tank_dir) begin
                // Rotation-only frame: facing changes, position does not.
                r_state  <= c_S_TURN;
                tank_dir <= w_key_dir;
            end else begin
                // Stays in MOVE even when clamped at an edge.
                r_state <= c_S_MOVE;
                tankX   <= w_x_next;
                tankY   <= w_y_next;
            end
        end
    end

    assign moving = (r_state == c_S_MOVE);

    // 11-bit compares so tankX+Width cannot overflow near the right edge.
    assign is_tank = ({1'b0, DrawX} >= {1'b0, tankX}) &&
                     ({1'b0, DrawX} <= ({1'b0, tankX} + {1'b0, Width} - 11'd1)) &&
                     ({1'b0, DrawY} >= {1'b0, tankY}) &&
                     ({1'b0, DrawY} <= ({1'b0, tankY} + {1'b0, Height} - 11'd1));

endmodule
`default_nettype wire

// File: tb/tb_tank_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_motion
// Purpose  : Self-checking bench for tank_motion. A behavioural model keeps
//            the tank position, facing and motion flag as plain integers and
//            is advanced once per frame; directed scenarios cover reset,
//            turn-then-move, edge clamping, idle and asynchronous reset,
//            followed by a randomized keycode run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tank_motion;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] tankX;
    logic [9:0] tankY;
    logic [2:0] tank_dir;
    logic       is_tank;
    logic       moving;

    tank_motion dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .keycode  (keycode),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .tankX    (tankX),
        .tankY    (tankY),
        .tank_dir (tank_dir),
        .is_tank  (is_tank),
        .moving   (moving)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_x, m_y, m_dir, m_mov;
    localparam int c_XL = 639 - 50 + 1;
    localparam int c_YL = 479 - 50 + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int key_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 1;
            8'h07:   return 2;
            8'h04:   return 3;
            8'h16:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_x = 295; m_y = 215; m_dir = 1; m_mov = 0;
    endtask

    task automatic model_frame(input logic [7:0] k);
        int d;
        d = key_dir(k);
        if (d == 0) begin
            m_mov = 0;
        end else if (d != m_dir) begin
            m_dir = d; m_mov = 0;
        end else begin
            m_mov = 1;
            case (d)
                1: m_y = (m_y - 2 < 0) ? 0 : m_y - 2;
                4: m_y = (m_y + 2 > c_YL) ? c_YL : m_y + 2;
                3: m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
                default: m_x = (m_x + 2 > c_XL) ? c_XL : m_x + 2;
            endcase
        end
    endtask

    // One frame: keycode valid around the tick, then replaced by junk so a
    // late key change must not matter. Model advances alongside.
    task automatic frame(input logic [7:0] k, input logic [7:0] junk);
        @(negedge Clk);
        keycode   = k;
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        keycode   = junk;
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        model_frame(k);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".x"},   int'(tankX),    m_x);
        chk({tag, ".y"},   int'(tankY),    m_y);
        chk({tag, ".dir"}, int'(tank_dir), m_dir);
        chk({tag, ".mov"}, int'(moving),   m_mov);
    endtask

    task automatic chk_pix(input string tag, input int dx, input int dy);
        int e;
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        #1;
        e = (dx >= m_x && dx <= m_x + 49 && dy >= m_y && dy <= m_y + 49) ? 1 : 0;
        chk(tag, int'(is_tank), e);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    logic [7:0] keys [5] = '{8'h00, 8'h1A, 8'h07, 8'h04, 8'h16};

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; keycode = 8'h00;
        DrawX = 10'd0; DrawY = 10'd0;
        do_reset();

        // Reset values and sprite extent
        chk("rst.x", int'(tankX), 295);
        chk("rst.y", int'(tankY), 215);
        chk("rst.dir", int'(tank_dir), 1);
        chk("rst.mov", int'(moving), 0);
        chk_pix("rst.pix_in", 295, 215);
        chk_pix("rst.pix_out", 345, 215);

        // Turn right, then two moves
        frame(8'h07, 8'h16);
        chk("t1.dir", int'(tank_dir), 2);
        chk("t1.x", int'(tankX), 295);
        frame(8'h07, 8'h04);
        chk("t2.x", int'(tankX), 297);
        frame(8'h07, 8'h00);
        chk("t3.x", int'(tankX), 299);
        chk("t3.mov", int'(moving), 1);

        // Drive right to 589, then clamp at 590
        while (m_x < 589) frame(8'h07, 8'h1A);
        chk("edge.pre", int'(tankX), 589);
        frame(8'h07, 8'h00);
        chk("edge.x590", int'(tankX), 590);
        repeat (2) frame(8'h07, 8'h04);
        chk("edge.hold", int'(tankX), 590);
        chk("edge.mov", int'(moving), 1);
        chk_pix("edge.pix", 639, 240);

        // Turn up, drive to y=1, then clamp at 0
        frame(8'h1A, 8'h07);
        while (m_y > 1) frame(8'h1A, 8'h16);
        chk("top.pre", int'(tankY), 1);
        frame(8'h1A, 8'h00);
        chk("top.y0", int'(tankY), 0);
        frame(8'h1A, 8'h00);
        chk("top.hold", int'(tankY), 0);

        // Left key between ticks, none at tick -> idle
        @(negedge Clk); keycode = 8'h04;
        repeat (2) @(negedge Clk);
        frame(8'h00, 8'h04);
        chk_state("idle");

        // Async reset mid-frame while moving
        frame(8'h1A, 8'h00);
        chk("pre_ar.mov", int'(moving), 1);
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        model_reset();
        chk_state("async_rst");
        @(negedge Clk);
        Reset = 1'b0;
        frame(8'h1A, 8'h00);
        chk_state("post_rst");

        // Randomized frames
        for (int i = 0; i < 300; i++) begin
            logic [7:0] k, j;
            k = ($urandom_range(0, 9) == 0) ? 8'($urandom) : keys[$urandom_range(0, 4)];
            j = 8'($urandom);
            frame(k, j);
            chk_state("rnd");
            chk_pix("rnd.pix", m_x + $urandom_range(0, 60) - 5, m_y + $urandom_range(0, 60) - 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
